// File: rtl/rom_loader_mc.sv
// rom_loader_mc: BL616 byte-stream ROM loader that packs data bytes into SDRAM write words through a FIFO.
// Define ROM_LOADER_CKSUM_EN to expect a trailing 8-bit checksum byte after END.
module rom_loader_mc #(
   parameter int ADDR_W     = 25,
   parameter int TYPE_W     = 3,
   parameter int WORD_BYTES = 2,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                    clk_27m,
   input  logic                    reset_n,
   input  logic [7:0]              in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    wr_req,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [8*WORD_BYTES-1:0] wr_data,
   output logic [WORD_BYTES-1:0]   wr_be,
   input  logic                    wr_ack,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [ADDR_W-1:0]       bytes_loaded
);
   localparam int OFF_W = ADDR_W - TYPE_W;
   localparam int LB    = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;
   localparam int DW    = 8 * WORD_BYTES;

   typedef enum logic [3:0] {
      ST_IDLE, ST_TYPE, ST_A2, ST_A1, ST_A0, ST_S2, ST_S1, ST_S0,
      ST_CMD, ST_DATA, ST_END, ST_CKS, ST_DRAIN, ST_ERR
   } state_t;

   state_t                state, state_n;
   logic [TYPE_W-1:0]     rtype;
   logic [23:0]           offset, size;
   logic [7:0]            cksum;
   logic [DW-1:0]         word_buf, word_n, stage_data;
   logic [WORD_BYTES-1:0] be_buf, be_n, stage_be;
   logic [ADDR_W-1:0]     stage_addr;
   logic                  push;
   logic [ADDR_W-1:0]     fifo_addr [FIFO_DEPTH];
   logic [DW-1:0]         fifo_data [FIFO_DEPTH];
   logic [WORD_BYTES-1:0] fifo_be   [FIFO_DEPTH];
   logic [PW-1:0]         wp, rp;
   logic [CW-1:0]         count;
   logic [ADDR_W:0]       off_sum;
   logic [LB-1:0]         lane;
   logic                  accept, start, pop, full, overflow, last, fifo_idle;

   // off_sum is the region offset of the byte currently being offered in DATA
   assign off_sum   = (ADDR_W+1)'(offset) + (ADDR_W+1)'(bytes_loaded);
   assign overflow  = |off_sum[ADDR_W:OFF_W];
   assign lane      = WORD_BYTES == 1 ? '0 : bytes_loaded[LB-1:0];
   assign last      = bytes_loaded + ADDR_W'(1) == ADDR_W'(size);
   assign full      = count + CW'(push) >= CW'(FIFO_DEPTH);
   assign fifo_idle = count == '0 && !push;
   assign pop       = wr_req & wr_ack;
   assign accept    = in_valid & in_ready;
   assign start     = accept && in_data == 8'h01 && (state == ST_IDLE || state == ST_ERR);
   assign wr_req    = count != '0;
   assign wr_addr   = wr_req ? fifo_addr[rp] : '0;
   assign wr_data   = wr_req ? fifo_data[rp] : '0;
   assign wr_be     = wr_req ? fifo_be[rp] : '0;
   assign busy      = state != ST_IDLE || !fifo_idle;

   always_comb begin
      word_n = word_buf;
      be_n = be_buf;
      word_n[8*lane +: 8] = in_data;
      be_n[lane] = 1'b1;
   end

   always_comb begin
      state_n  = state;
      in_ready = !(state == ST_DRAIN || (state == ST_DATA && full));
      done     = 1'b0;
      if (state == ST_DRAIN) begin
         done    = fifo_idle;
         state_n = fifo_idle ? ST_IDLE : ST_DRAIN;
      end else if (accept) begin
         case (state)
            ST_IDLE, ST_ERR: state_n = in_data == 8'h01 ? ST_TYPE : state;
            ST_TYPE: state_n = |(in_data >> TYPE_W) ? ST_ERR : ST_A2;
            ST_A2:   state_n = ST_A1;
            ST_A1:   state_n = ST_A0;
            ST_A0:   state_n = |(in_data & 8'(WORD_BYTES-1)) ? ST_ERR : ST_S2;
            ST_S2:   state_n = ST_S1;
            ST_S1:   state_n = ST_S0;
            ST_S0:   state_n = ST_CMD;
            ST_CMD:  state_n = in_data != 8'h02 ? ST_ERR : size == '0 ? ST_END : ST_DATA;
            ST_DATA: state_n = overflow ? ST_ERR : last ? ST_END : ST_DATA;
`ifdef ROM_LOADER_CKSUM_EN
            ST_END:  state_n = in_data == 8'h03 ? ST_CKS : ST_ERR;
            ST_CKS:  state_n = ST_DRAIN;
`else
            ST_END:  state_n = in_data == 8'h03 ? ST_DRAIN : ST_ERR;
`endif
            default: state_n = state;
         endcase
      end
   end

   always_ff @(posedge clk_27m) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         rtype        <= '0;
         offset       <= '0;
         size         <= '0;
         cksum        <= '0;
         word_buf     <= '0;
         be_buf       <= '0;
         stage_addr   <= '0;
         stage_data   <= '0;
         stage_be     <= '0;
         push         <= 1'b0;
         wp           <= '0;
         rp           <= '0;
         count        <= '0;
         err          <= 1'b0;
         bytes_loaded <= '0;
      end else begin
         state <= state_n;
         push  <= 1'b0;
         count <= count + CW'(push) - CW'(pop);
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         if (start) begin
            err          <= 1'b0;
            bytes_loaded <= '0;
            cksum        <= '0;
         end
         if (state_n == ST_ERR) err <= 1'b1;
         if (accept) begin
            case (state)
               ST_TYPE: rtype <= in_data[TYPE_W-1:0];
               ST_A2:   offset[23:16] <= in_data;
               ST_A1:   offset[15:8] <= in_data;
               ST_A0:   offset[7:0] <= in_data;
               ST_S2:   size[23:16] <= in_data;
               ST_S1:   size[15:8] <= in_data;
               ST_S0:   size[7:0] <= in_data;
               ST_DATA: if (!overflow) begin
                  bytes_loaded <= bytes_loaded + 1'b1;
                  cksum        <= cksum + in_data;
                  // aligned start means an overflowing byte always opens a fresh word
                  if (lane == LB'(WORD_BYTES-1) || last) begin
                     push       <= 1'b1;
                     stage_addr <= {rtype, off_sum[OFF_W-1:0]} & ~ADDR_W'(WORD_BYTES-1);
                     stage_data <= word_n;
                     stage_be   <= be_n;
                     word_buf   <= '0;
                     be_buf     <= '0;
                  end else begin
                     word_buf <= word_n;
                     be_buf   <= be_n;
                  end
               end
`ifdef ROM_LOADER_CKSUM_EN
               ST_CKS:  if (8'(cksum + in_data) != 8'h00) err <= 1'b1;
`endif
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_27m) begin
      if (push) begin
         fifo_addr[wp] <= stage_addr;
         fifo_data[wp] <= stage_data;
         fifo_be[wp]   <= stage_be;
      end
   end
endmodule

// File: tb/tb_rom_loader_mc.sv
// tb_rom_loader_mc: randomized loads checked against a per-load write list built from the protocol rules.
// Define ROM_LOADER_CKSUM_EN to exercise the checksum byte.
module tb_rom_loader_mc;
   logic        clk_27m = 1'b0;
   logic        reset_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        wr_req;
   logic [24:0] wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_be;
   logic        wr_ack;
   logic        busy, done, err;
   logic [24:0] bytes_loaded;

   int n_cmp = 0, n_bad = 0, done_cnt = 0, max_gap = 0;
   bit ack_hold = 1'b0, ck_bad = 1'b0;
   logic [24:0] exp_a[$], act_a[$];
   logic [15:0] exp_d[$], act_d[$];
   logic [1:0]  exp_b[$], act_b[$];
   logic [7:0]  payload[$], seq[$];

   rom_loader_mc dut (
      .clk_27m(clk_27m), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .wr_ack(wr_ack), .busy(busy), .done(done), .err(err),
      .bytes_loaded(bytes_loaded)
   );

   always #5 clk_27m = ~clk_27m;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit acc = 1'b0;
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk_27m); #1; end
      in_valid = 1'b1;
      in_data  = b;
      for (int c = 0; c < 5000 && !acc; c++) begin
         @(negedge clk_27m);
         acc = in_ready;
         @(posedge clk_27m);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         n_bad++;
         $display("FAIL send_timeout: in_ready got 0 expected 1");
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $fatal(1, "byte never accepted");
      end
   endtask

   task automatic send_all();
      foreach (seq[i]) send_byte(seq[i]);
   endtask

   // builds the expected word writes, streams the load, then waits for the done pulse
   task automatic run_load(input logic [2:0] t, input logic [23:0] a);
      int n = payload.size();
      int c = 0;
      logic [7:0]  s = 8'h00;
      logic [15:0] d;
      logic [1:0]  b;
      act_a.delete(); act_d.delete(); act_b.delete();
      for (int i = 0; i < n; i += 2) begin
         d = '0;
         b = '0;
         for (int j = 0; j < 2; j++)
            if (i + j < n) begin
               d[8*j +: 8] = payload[i+j];
               b[j] = 1'b1;
            end
         exp_a.push_back(({t, 22'd0} | 25'(a)) + 25'(i));
         exp_d.push_back(d);
         exp_b.push_back(b);
      end
      foreach (payload[i]) s = s + payload[i];
      seq = '{8'h01, {5'd0, t}, a[23:16], a[15:8], a[7:0], 8'(n >> 16), 8'(n >> 8), 8'(n), 8'h02};
      send_all();
      foreach (payload[i]) send_byte(payload[i]);
      send_byte(8'h03);
`ifdef ROM_LOADER_CKSUM_EN
      send_byte(8'(8'h00 - s + 8'(ck_bad)));
`endif
      @(negedge clk_27m);
      while (!done && c < 3000) begin @(negedge clk_27m); c++; end
      chk("done_seen", done, 1);
      chk("err_after_load", err, ck_bad);
      chk("bytes_loaded", bytes_loaded, n);
      chk("writes_outstanding", exp_a.size(), 0);
      @(negedge clk_27m);
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
      @(posedge clk_27m);
      #1;
   endtask

   initial begin
      wr_ack = 1'b0;
      forever begin
         @(posedge clk_27m);
         #1;
         wr_ack = ack_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // scoreboard: every accepted write must be the next expected word, held stable until acked
   initial begin
      logic pr = 1'b0, pk = 1'b0;
      logic [24:0] pa;
      logic [15:0] pd;
      logic [1:0]  pb;
      forever begin
         @(negedge clk_27m);
         if (!reset_n) begin
            pr = 1'b0;
            continue;
         end
         if (done) done_cnt++;
         if (pr && !pk) begin
            chk("hold_req", wr_req, 1);
            chk("hold_addr", wr_addr, pa);
            chk("hold_data", wr_data, pd);
            chk("hold_be", wr_be, pb);
         end
         if (wr_req && wr_ack) begin
            act_a.push_back(wr_addr);
            act_d.push_back(wr_data);
            act_b.push_back(wr_be);
            if (exp_a.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
            end else begin
               chk("wr_addr", wr_addr, exp_a.pop_front());
               chk("wr_data", wr_data, exp_d.pop_front());
               chk("wr_be", wr_be, exp_b.pop_front());
            end
         end
         pr = wr_req; pk = wr_ack; pa = wr_addr; pd = wr_data; pb = wr_be;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk_27m);
      @(negedge clk_27m);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_wr_req", wr_req, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_wr_be", wr_be, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_bytes_loaded", bytes_loaded, 0);
      @(posedge clk_27m); #1 reset_n = 1'b1;

      payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_load(3'd1, 24'h000010);
      chk("t1_addr0", act_a[0], 25'h400010);
      chk("t1_data0", act_d[0], 16'hBBAA);
      chk("t1_addr1", act_a[1], 25'h400012);
      chk("t1_data1", act_d[1], 16'hDDCC);
      chk("t1_be1", act_b[1], 2'b11);

      payload = '{8'h11, 8'h22, 8'h33};
      run_load(3'd0, 24'h000020);
      chk("t2_addr1", act_a[1], 25'h000022);
      chk("t2_data1", act_d[1], 16'h0033);
      chk("t2_be1", act_b[1], 2'b01);
      chk("t2_bytes", bytes_loaded, 3);

      ack_hold = 1'b1;
      payload.delete();
      repeat (64) payload.push_back(8'($urandom));
      fork
         begin
            repeat (200) @(negedge clk_27m);
            chk("t3_in_ready_low", in_ready, 0);
            chk("t3_bytes_at_stall", bytes_loaded, 16);
            chk("t3_no_writes", act_a.size(), 0);
            ack_hold = 1'b0;
         end
      join_none
      run_load(3'd2, 24'h000100);
      chk("t3_write_count", act_a.size(), 32);

      seq = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h01};
      send_all();
      @(negedge clk_27m);
      chk("t4_misaligned_err", err, 1);
      chk("t4_err_in_ready", in_ready, 1);
      chk("t4_err_busy", busy, 1);
      @(posedge clk_27m); #1;
      seq = '{8'h01};
      send_all();
      @(negedge clk_27m);
      chk("t4_start_clears_err", err, 0);
      @(posedge clk_27m); #1;
      seq = '{8'h08};
      send_all();
      @(negedge clk_27m);
      chk("t4_type_err", err, 1);
      @(posedge clk_27m); #1;
      seq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h05};
      send_all();
      @(negedge clk_27m);
      chk("t4_cmd_err", err, 1);
      @(posedge clk_27m); #1;
      payload = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E, 8'hAF};
      run_load(3'd3, 24'h000200);

      // last stored byte at region top; the next byte overflows and must not be written
      d0 = done_cnt;
      act_a.delete();
      exp_a.push_back(25'h17FFFFE); exp_d.push_back(16'hA1A0); exp_b.push_back(2'b11);
      seq = '{8'h01, 8'h05, 8'h3F, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h04, 8'h02,
              8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h03};
      send_all();
      for (int c = 0; c < 2000 && exp_a.size() != 0; c++) @(negedge clk_27m);
      @(negedge clk_27m);
      chk("ovf_writes_outstanding", exp_a.size(), 0);
      chk("ovf_err", err, 1);
      chk("ovf_bytes", bytes_loaded, 2);
      chk("ovf_no_done", done_cnt - d0, 0);
      chk("ovf_write_count", act_a.size(), 1);
      @(posedge clk_27m); #1;
      payload = '{8'h01, 8'h02, 8'h03};
      run_load(3'd7, 24'h3FFFFC);

      ack_hold = 1'b1;
      seq = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h02,
              8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      send_all();
      reset_n = 1'b0;
      @(negedge clk_27m);
      @(negedge clk_27m);
      chk("t5_wr_req", wr_req, 0);
      chk("t5_busy", busy, 0);
      chk("t5_in_ready", in_ready, 1);
      chk("t5_bytes", bytes_loaded, 0);
      @(posedge clk_27m); #1;
      reset_n = 1'b1;
      ack_hold = 1'b0;
      act_a.delete();
      repeat (20) @(posedge clk_27m);
      #1;
      chk("t5_fifo_dropped", act_a.size(), 0);

      for (int k = 0; k < 25; k++) begin
         int n;
         logic [23:0] a;
         max_gap = k % 3;
         n = (k % 5 == 0) ? $urandom_range(1, 40) : $urandom_range(0, 40);
         a = (k % 5 == 0) ? 24'h400000 - 24'(n) : 24'($urandom_range(0, 32'h3FFFFF - 41));
         a[0] = 1'b0;
         payload.delete();
         repeat (n) payload.push_back(8'($urandom));
         run_load(3'($urandom_range(0, 7)), a);
      end

`ifdef ROM_LOADER_CKSUM_EN
      max_gap = 0;
      payload = '{8'h01, 8'h02};
      run_load(3'd0, 24'h000040);
      ck_bad = 1'b1;
      run_load(3'd0, 24'h000040);
      ck_bad = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
